// File: rtl/rx_ram_pkg.sv
// Shared types and default sizing for the receive-side buffer.
package rx_ram_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rx_ram_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one registered read port.
// Define RX_RAM_BYPASS_EN for write-first behaviour on a same-address collision.
module rx_ram_mem #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_q <= '0;
    end else begin
`ifdef RX_RAM_BYPASS_EN
      if (we_i && (waddr_i == raddr_i)) rd_q <= wdata_i;
      else                              rd_q <= mem_q[raddr_i];
`else
      rd_q <= mem_q[raddr_i];
`endif
    end
  end

  assign rdata_o = rd_q;

endmodule

// File: rtl/rx_ram.sv
// Receive buffer: streams words via valid/ready into consecutive wrapping
// addresses from base_addr, pulses done after xfer_len words.
// Collision read behaviour selected by RX_RAM_BYPASS_EN (see rx_ram_mem).
module rx_ram
  import rx_ram_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   xfer_len,
  input  logic                  rx_valid,
  input  logic [WIDTH-1:0]      rx_data,
  output logic                  rx_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  wr_en;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          wr_ptr_d = base_addr;
          len_d    = (xfer_len > DEPTH_L) ? DEPTH_L : xfer_len;
          cnt_d    = '0;
          state_d  = (xfer_len != '0) ? RECV : DONE;
        end
      end
      RECV: begin
        if (rx_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

  // Handshake outputs decode the registered state only.
  assign rx_ready = (state_q == RECV);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign wr_count = cnt_q;

  // A beat arriving on the reset edge is dropped.
  rx_ram_mem #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .we_i    (wr_en & rst_n),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_rx_ram.sv
// Directed self-checking bench for rx_ram; inputs driven and outputs sampled
// 1ns after each rising edge.
module tb_rx_ram;

  logic       clk = 1'b0;
  logic       rst_n, start, rx_valid, rx_ready, busy, done;
  logic [2:0] base_addr, rd_addr;
  logic [3:0] xfer_len, wr_count;
  logic [7:0] rx_data, rd_data;

  int n_chk = 0;
  int n_fail = 0;

  rx_ram dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .xfer_len(xfer_len), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .busy(busy), .done(done), .wr_count(wr_count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [2:0] b, input logic [3:0] l);
    start = 1'b1; base_addr = b; xfer_len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: actual=%b required=0", rx_ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: actual=%b required=0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: actual=%b required=0", done); end
    n_chk++; if (wr_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: actual=%0d required=0", wr_count); end
    n_chk++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: actual=%h required=00", rd_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_burst();
    start_xfer(3'd0, 4'd8);
    n_chk++; if (rx_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL burst_ready: actual=%b%b required=11", rx_ready, busy); end
    for (int i = 0; i < 8; i++) beat(8'h10 + 8'(i));
    n_chk++; if (done !== 1'b1 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL burst_done: actual=%b%b required=10", done, rx_ready); end
    n_chk++; if (wr_count !== 4'd8) begin n_fail++; $display("FAIL burst_count: actual=%0d required=8", wr_count); end
    tick();
    n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL burst_idle: actual=%b%b required=00", done, busy); end
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      tick();
      n_chk++; if (rd_data !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL burst_read%0d: actual=%h required=%h", i, rd_data, 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_idle_ignore();
    rx_valid = 1'b1; rx_data = 8'hAA;
    tick(); tick();
    rx_valid = 1'b0;
    n_chk++; if (wr_count !== 4'd8 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL idle_state: actual=%0d/%b required=8/0", wr_count, rx_ready); end
    rd_addr = 3'd0;
    tick();
    n_chk++; if (rd_data !== 8'h10) begin n_fail++; $display("FAIL idle_mem0: actual=%h required=10", rd_data); end
  endtask

  task automatic test_wrap_backpressure();
    logic [5:0] pat;
    int k;
    pat = 6'b101101;
    k = 0;
    start_xfer(3'd6, 4'd4);
    for (int i = 0; i < 6; i++) begin
      rx_valid = pat[5-i];
      rx_data  = pat[5-i] ? 8'hA0 + 8'(k) : 8'hEE;
      if (pat[5-i]) k++;
      tick();
    end
    rx_valid = 1'b0;
    n_chk++; if (done !== 1'b1 || wr_count !== 4'd4) begin n_fail++; $display("FAIL wrap_done: actual=%b/%0d required=1/4", done, wr_count); end
    for (int i = 0; i < 5; i++) begin
      logic [2:0] a;
      logic [7:0] e;
      a = (i == 4) ? 3'd2 : 3'(6 + i);
      e = (i == 4) ? 8'h12 : 8'hA0 + 8'(i);
      rd_addr = a;
      tick();
      n_chk++; if (rd_data !== e) begin n_fail++; $display("FAIL wrap_read@%0d: actual=%h required=%h", a, rd_data, e); end
    end
  endtask

  task automatic test_zero_and_ignored_start();
    start_xfer(3'd3, 4'd0);
    n_chk++; if (done !== 1'b1 || rx_ready !== 1'b0 || wr_count !== 4'd0) begin n_fail++; $display("FAIL zero_done: actual=%b%b/%0d required=10/0", done, rx_ready, wr_count); end
    tick();
    n_chk++; if (done !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL zero_idle: actual=%b%b%b required=000", done, busy, rx_ready); end
    start_xfer(3'd4, 4'd3);
    beat(8'hC0);
    start_xfer(3'd0, 4'd1);
    n_chk++; if (wr_count !== 4'd1 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL ign_start: actual=%0d/%b required=1/1", wr_count, rx_ready); end
    beat(8'hC1);
    n_chk++; if (done !== 1'b0 || wr_count !== 4'd2) begin n_fail++; $display("FAIL ign_len: actual=%b/%0d required=0/2", done, wr_count); end
    beat(8'hC2);
    n_chk++; if (done !== 1'b1 || wr_count !== 4'd3) begin n_fail++; $display("FAIL ign_done: actual=%b/%0d required=1/3", done, wr_count); end
    tick();
    rd_addr = 3'd6; tick();
    n_chk++; if (rd_data !== 8'hC2) begin n_fail++; $display("FAIL ign_ptr: actual=%h required=c2", rd_data); end
    rd_addr = 3'd0; tick();
    n_chk++; if (rd_data !== 8'hA2) begin n_fail++; $display("FAIL ign_addr0: actual=%h required=a2", rd_data); end
  endtask

  task automatic test_clamp();
    start_xfer(3'd0, 4'd12);
    for (int i = 0; i < 8; i++) beat(8'h30 + 8'(i));
    n_chk++; if (done !== 1'b1 || wr_count !== 4'd8) begin n_fail++; $display("FAIL clamp_done: actual=%b/%0d required=1/8", done, wr_count); end
    tick();
  endtask

  task automatic test_reset_mid();
    start_xfer(3'd0, 4'd6);
    for (int i = 0; i < 3; i++) beat(8'h40 + 8'(i));
    rst_n = 1'b0; rx_valid = 1'b1; rx_data = 8'h43;
    tick();
    rst_n = 1'b1; rx_valid = 1'b0;
    n_chk++; if (busy !== 1'b0 || wr_count !== 4'd0 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: actual=%b/%0d/%b required=0/0/0", busy, wr_count, rx_ready); end
    n_chk++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rd: actual=%h required=00", rd_data); end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 3'(i);
      tick();
      n_chk++; if (rd_data !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL rstmid_read%0d: actual=%h required=%h", i, rd_data, 8'h40 + 8'(i)); end
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp_c;
`ifdef RX_RAM_BYPASS_EN
    exp_c = 8'h66;
`else
    exp_c = 8'h55;
`endif
    start_xfer(3'd2, 4'd1);
    beat(8'h55);
    tick();
    rd_addr = 3'd2;
    start_xfer(3'd2, 4'd1);
    beat(8'h66);
    n_chk++; if (rd_data !== exp_c) begin n_fail++; $display("FAIL collide_rd: actual=%h required=%h", rd_data, exp_c); end
    tick();
    n_chk++; if (rd_data !== 8'h66) begin n_fail++; $display("FAIL collide_next: actual=%h required=66", rd_data); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; xfer_len = '0;
    rx_valid = 1'b0; rx_data = '0; rd_addr = '0;
    #1;
    test_reset();
    test_burst();
    test_idle_ignore();
    test_wrap_backpressure();
    test_zero_and_ignored_start();
    test_clamp();
    test_reset_mid();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
